pwm_generator: RTL and testbench

//   Start-triggered, four-channel sequential PWM burst generator.
//   A rising edge on start launches one burst: channels d_c[0]..d_c[3] each emit
//   one pulse in turn (high t1 cycles, then low t2 cycles), then the block idles.

---
 rtl/pwm_generator.sv | 106 ++++++++++
 tb/tb_pwm_generator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// pwm_generator
//
// Start-triggered, four-channel sequential PWM burst generator. A rising
// edge on start launches one burst. Channels d_c[0]..d_c[3] then each emit
// one pulse in turn: high for t1 cycles, then low for t2 cycles. After the
// last channel the block idles until it sees a fresh 0->1 on start.
//
// Parameters
//   t1     high-phase length per channel in clk cycles (1..63)
//   t2     low-phase length per channel in clk cycles (1..63)
//
// Ports
//   clk    in   1  system clock, all logic on posedge
//   rst    in   1  synchronous reset, active-low
//   start  in   1  burst request, rising edge triggers
//   d_c    out  4  per-channel PWM outputs, at most one bit high
module pwm_generator #(
    parameter logic [5:0] t1 = 6'd20,
    parameter logic [5:0] t2 = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] d_c
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t     r_state;
    logic [1:0] r_chan;
    logic [5:0] r_count;
    logic       r_startPrev;
    logic [3:0] r_dc;

    logic       w_rise;
    logic [1:0] w_nextChan;

    assign w_rise     = start & ~r_startPrev;
    assign w_nextChan = r_chan + 2'd1;
    assign d_c        = r_dc;

    // The start history keeps tracking during a burst, so a level held
    // across the end of a burst never looks like a new edge. Edges seen
    // outside IDLE are simply dropped, which also covers an edge landing
    // on the same cycle the burst finishes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_chan      <= 2'd0;
            r_count     <= 6'd0;
            r_startPrev <= 1'b0;
            r_dc        <= 4'b0000;
        end else begin
            r_startPrev <= start;
            case (r_state)
                IDLE: begin
                    r_dc <= 4'b0000;
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_chan  <= 2'd0;
                        r_count <= 6'd0;
                        r_dc    <= 4'b0001;
                    end
                end
                HIGH: begin
                    if (r_count == t1 - 6'd1) begin
                        r_state <= LOW;
                        r_count <= 6'd0;
                        r_dc    <= 4'b0000;
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                LOW: begin
                    if (r_count == t2 - 6'd1) begin
                        r_count <= 6'd0;
                        if (r_chan == 2'd3) begin
                            r_state <= IDLE;
                            r_chan  <= 2'd0;
                            r_dc    <= 4'b0000;
                        end else begin
                            // Output is loaded from the next channel index so
                            // the pulse starts on the same edge as the state.
                            r_state <= HIGH;
                            r_chan  <= w_nextChan;
                            r_dc    <= 4'b0001 << w_nextChan;
                        end
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_chan  <= 2'd0;
                    r_count <= 6'd0;
                    r_dc    <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator
//
// Directed bench for pwm_generator at t1=20, t2=30, 20 ns clock.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Cycle k of a burst is the k-th falling edge after the trigger edge, so
// channel k/50 is high while k%50 < 20, and the block is idle from k=200.
module tb_pwm_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] d_c;

    int checkCount;
    int errCount;

    pwm_generator #(
        .t1(6'd20),
        .t2(6'd30)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .d_c  (d_c)
    );

    // 20 ns period clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Expected d_c on burst cycle k, written from the burst timeline
    function automatic logic [3:0] burstValue(input int k);
        logic [3:0] one;
        one = 4'b0001;
        if (k >= 200) return 4'b0000;
        if ((k % 50) < 20) return one << (k / 50);
        return 4'b0000;
    endfunction

    // Walks burst cycles 0..lastK after a trigger set up on the previous
    // falling edge; optionally drops/raises start after given cycles.
    task automatic applyStimulus(input string tag, input int dropAt,
                                 input int riseAt, input int lastK);
        for (int k = 0; k <= lastK; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s k=%0d", tag, k), d_c, burstValue(k));
            if (k == dropAt) start = 1'b0;
            if (k == riseAt) start = 1'b1;
        end
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s idle=%0d", tag, i), d_c, 4'b0000);
        end
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        rst        = 1'b0;
        start      = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", d_c, 4'b0000);

        // Release with start already high: first edge is a rising edge.
        // Start stays high across the whole burst and beyond.
        rst   = 1'b1;
        start = 1'b1;
        applyStimulus("burst1", -1, -1, 199);
        checkIdle("held", 30);

        // Fresh edge gives a second burst; a retrigger mid-burst is ignored
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        applyStimulus("retrig", 10, 24, 199);
        checkIdle("retrig", 10);

        // 5-cycle start pulse
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        applyStimulus("pulse5", 4, -1, 199);
        checkIdle("pulse5", 10);

        // 8-cycle start pulse
        start = 1'b1;
        applyStimulus("pulse8", 7, -1, 199);
        checkIdle("pulse8", 10);

        // Reset while channel 2 is high
        start = 1'b1;
        applyStimulus("preRst", 3, -1, 110);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midRst", d_c, 4'b0000);
        rst = 1'b1;
        checkIdle("postRst", 30);

        // A new rising edge after the abandoned burst runs a full burst
        start = 1'b1;
        applyStimulus("afterRst", 5, -1, 199);
        checkIdle("afterRst", 10);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
